// File: rtl/sgd_predict.sv
// -----------------------------------------------------------------------------
// sgd_predict
//
// Inference stage that sits after the SGD trainer. It captures the trained
// weight vector on the rising edge of the trainer's done level. It then
// evaluates y_hat = w0 + sum(wk * xk) over streamed data points. The data
// points use the same packed layout the trainer reads. Each prediction is
// returned with its residual (y - y_hat) over a valid/ready handshake.
//
// Packed vector layout (w_in and x_in): field k sits in
// [(DATA_WIDTH-1) - LENGTH*k -: LENGTH]. Field 0 is the bias w0 in w_in and
// the target y in x_in. Fields 1..MAX_FEATURES are the weights and features.
//
// Ports
//   CLK       in   clock, all logic on the rising edge
//   RST       in   synchronous active-high reset
//   w_in      in   packed weight vector
//   w_load    in   trainer done level; its rising edge captures w_in
//   x_in      in   packed data point (y in field 0)
//   x_valid   in   x_in valid
//   x_ready   out  block accepts x_in this cycle
//   feat      in   active feature count, sampled when x is accepted
//   y_out     out  saturated prediction
//   res_out   out  saturated residual y - y_hat
//   y_valid   out  y_out / res_out valid
//   y_ready   in   consumer accepts the result
//   w_loaded  out  a weight vector has been captured since reset
// -----------------------------------------------------------------------------
module sgd_predict #(
  parameter int MAX_FEATURES = 15,
  parameter int LENGTH       = 16,
  parameter int DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1),
  parameter int FRAC_BITS    = 8,
  parameter int MAX_MUL      = 3
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic [DATA_WIDTH-1:0]              w_in,
  input  logic                               w_load,
  input  logic [DATA_WIDTH-1:0]              x_in,
  input  logic                               x_valid,
  output logic                               x_ready,
  input  logic [$clog2(MAX_FEATURES+1)-1:0]  feat,
  output logic [LENGTH-1:0]                  y_out,
  output logic [LENGTH-1:0]                  res_out,
  output logic                               y_valid,
  input  logic                               y_ready,
  output logic                               w_loaded
);

  localparam int FEAT_W = $clog2(MAX_FEATURES + 1);
  // k runs past MAX_FEATURES by up to MAX_MUL on the last MAC step.
  localparam int K_W    = $clog2(MAX_FEATURES + MAX_MUL + 1);
  // Headroom for MAX_FEATURES+1 terms of LENGTH bits each.
  localparam int ACC_W  = LENGTH + 8;

  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'((2 ** (LENGTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(-(2 ** (LENGTH - 1)));
  localparam logic [LENGTH-1:0] OUT_MAX = {1'b0, {(LENGTH-1){1'b1}}};
  localparam logic [LENGTH-1:0] OUT_MIN = {1'b1, {(LENGTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_WAIT_W,
    S_IDLE,
    S_MAC,
    S_OUT
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t                   r_state;
  logic [DATA_WIDTH-1:0]    r_w;
  logic [DATA_WIDTH-1:0]    r_x;
  logic [FEAT_W-1:0]        r_feat;
  logic signed [ACC_W-1:0]  r_acc;
  logic [K_W-1:0]           r_k;
  logic                     r_pending;
  logic                     r_w_load_q;
  logic                     r_w_loaded;

  // ---------------------------------------------------------------------------
  // Control wires from the next-state process
  // ---------------------------------------------------------------------------
  state_t  w_state_next;
  logic    w_rise;
  logic    w_capture;   // copy w_in into the weight register
  logic    w_pend_set;  // a reload arrived while an evaluation is in flight
  logic    w_pend_clr;
  logic    w_accept;    // x_in is taken this cycle
  logic    w_mac;       // one MAC step this cycle

  assign w_rise   = w_load & ~r_w_load_q;
  assign w_loaded = r_w_loaded;

  // ---------------------------------------------------------------------------
  // Field unpacking: index 0 is bias / target, 1..MAX_FEATURES are features
  // ---------------------------------------------------------------------------
  logic signed [LENGTH-1:0] w_wf [MAX_FEATURES+1];
  logic signed [LENGTH-1:0] w_xf [MAX_FEATURES+1];

  for (genvar gi = 0; gi <= MAX_FEATURES; gi++) begin : g_fields
    assign w_wf[gi] = r_w[(DATA_WIDTH-1) - LENGTH*gi -: LENGTH];
    assign w_xf[gi] = r_x[(DATA_WIDTH-1) - LENGTH*gi -: LENGTH];
  end

  // ---------------------------------------------------------------------------
  // Multiplier lanes. Lane gi handles feature k+1+gi. A lane whose feature
  // index lies beyond the latched count contributes zero. This covers the
  // final partial step and also keeps the stale upper fields of x_in out of
  // the sum.
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0] w_prod_ext [MAX_MUL];

  for (genvar gi = 0; gi < MAX_MUL; gi++) begin : g_mul
    logic [K_W-1:0]            w_idx;
    logic                      w_active;
    logic [FEAT_W-1:0]         w_sel;
    logic signed [2*LENGTH-1:0] w_full;
    logic signed [LENGTH-1:0]  w_p16;

    assign w_idx    = r_k + K_W'(gi + 1);
    assign w_active = (w_idx <= K_W'(r_feat));
    assign w_sel    = w_active ? w_idx[FEAT_W-1:0] : '0;
    assign w_full   = w_wf[w_sel] * w_xf[w_sel];
    // Rescale back to the field format and keep the low LENGTH bits. This
    // wraps for out-of-range products, the same way the trainer does.
    assign w_p16    = LENGTH'(w_full >>> FRAC_BITS);
    assign w_prod_ext[gi] = w_active ? ACC_W'(w_p16) : '0;
  end

  logic signed [ACC_W-1:0] w_mac_sum;
  always_comb begin
    w_mac_sum = r_acc;
    for (int i = 0; i < MAX_MUL; i++) begin
      w_mac_sum = w_mac_sum + w_prod_ext[i];
    end
  end

  logic [K_W-1:0] w_k_plus;
  assign w_k_plus = r_k + K_W'(MAX_MUL);

  // ---------------------------------------------------------------------------
  // Output saturation and residual
  // ---------------------------------------------------------------------------
  logic signed [LENGTH-1:0] w_y_hat;
  logic signed [LENGTH:0]   w_res_wide;
  logic signed [LENGTH-1:0] w_res_sat;

  always_comb begin
    if (r_acc > ACC_MAX) begin
      w_y_hat = OUT_MAX;
    end else if (r_acc < ACC_MIN) begin
      w_y_hat = OUT_MIN;
    end else begin
      w_y_hat = r_acc[LENGTH-1:0];
    end
  end

  // Both operands are in range, so one extra bit holds the exact difference.
  assign w_res_wide = {w_xf[0][LENGTH-1], w_xf[0]} - {w_y_hat[LENGTH-1], w_y_hat};

  always_comb begin
    if (w_res_wide[LENGTH] != w_res_wide[LENGTH-1]) begin
      w_res_sat = w_res_wide[LENGTH] ? OUT_MIN : OUT_MAX;
    end else begin
      w_res_sat = w_res_wide[LENGTH-1:0];
    end
  end

  assign y_out   = y_valid ? w_y_hat   : '0;
  assign res_out = y_valid ? w_res_sat : '0;

  // ---------------------------------------------------------------------------
  // FSM: next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    x_ready      = 1'b0;
    y_valid      = 1'b0;
    w_capture    = 1'b0;
    w_pend_set   = 1'b0;
    w_pend_clr   = 1'b0;
    w_accept     = 1'b0;
    w_mac        = 1'b0;

    case (r_state)
      S_WAIT_W: begin
        if (w_rise) begin
          w_capture    = 1'b1;
          w_state_next = S_IDLE;
        end
      end

      S_IDLE: begin
        // A weight reload takes priority over a waiting data point. This
        // way the new point never sees a half-updated weight register.
        if (w_rise || r_pending) begin
          w_capture  = 1'b1;
          w_pend_clr = 1'b1;
        end else begin
          x_ready = 1'b1;
          if (x_valid) begin
            w_accept     = 1'b1;
            w_state_next = (feat == '0) ? S_OUT : S_MAC;
          end
        end
      end

      S_MAC: begin
        w_mac      = 1'b1;
        w_pend_set = w_rise;
        if (w_k_plus >= K_W'(r_feat)) begin
          w_state_next = S_OUT;
        end
      end

      S_OUT: begin
        y_valid    = 1'b1;
        w_pend_set = w_rise;
        if (y_ready) begin
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_WAIT_W;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_WAIT_W;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_w        <= '0;
      r_x        <= '0;
      r_feat     <= '0;
      r_acc      <= '0;
      r_k        <= '0;
      r_pending  <= 1'b0;
      r_w_load_q <= 1'b0;
      r_w_loaded <= 1'b0;
    end else begin
      // The history register clears on reset, so a w_load held high through
      // reset shows up as a rise on the first cycle afterwards.
      r_w_load_q <= w_load;

      if (w_capture) begin
        r_w        <= w_in;
        r_w_loaded <= 1'b1;
      end

      if (w_pend_set) begin
        r_pending <= 1'b1;
      end else if (w_pend_clr) begin
        r_pending <= 1'b0;
      end

      if (w_accept) begin
        r_x    <= x_in;
        r_feat <= feat;
        r_acc  <= ACC_W'(w_wf[0]);
        r_k    <= '0;
      end else if (w_mac) begin
        r_acc <= w_mac_sum;
        r_k   <= w_k_plus;
      end
    end
  end

endmodule

// File: tb/tb_sgd_predict.sv
`timescale 1ns/1ps
module tb_sgd_predict;

  localparam int MF = 15;
  localparam int L  = 16;
  localparam int DW = L * (MF + 1);

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [DW-1:0] w_in = '0;
  logic [DW-1:0] x_in = '0;
  logic          w_load = 1'b0;
  logic          x_valid = 1'b0;
  logic          y_ready = 1'b1;
  logic [3:0]    feat = 4'd0;
  logic          x_ready, y_valid, w_loaded;
  logic [L-1:0]  y_out, res_out;

  sgd_predict dut (
    .CLK      (CLK),
    .RST      (RST),
    .w_in     (w_in),
    .w_load   (w_load),
    .x_in     (x_in),
    .x_valid  (x_valid),
    .x_ready  (x_ready),
    .feat     (feat),
    .y_out    (y_out),
    .res_out  (res_out),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .w_loaded (w_loaded)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] y;
    logic [15:0] r;
    int          cyc;
  } exp_t;

  exp_t          q[$];
  exp_t          e;
  logic [31:0]   mres;
  logic [DW-1:0] model_w = '0;
  int            pops = 0;
  logic [15:0]   last_y = '0;
  logic [15:0]   last_res = '0;
  bit            seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic err(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // Behavioural model: straight arithmetic over the active features.
  function automatic logic [31:0] model(input logic [DW-1:0] w, input logic [DW-1:0] x, input int f);
    longint acc, p, yh, r;
    logic signed [15:0] a, b, t;
    a   = w[DW-1 -: 16];
    acc = a;
    for (int k = 1; k <= f; k++) begin
      a   = w[DW-1-16*k -: 16];
      b   = x[DW-1-16*k -: 16];
      p   = longint'(a) * longint'(b);
      p   = p >>> 8;
      t   = p[15:0];
      acc = acc + t;
    end
    yh = (acc > 32767) ? 32767 : ((acc < -32768) ? -32768 : acc);
    b  = x[DW-1 -: 16];
    r  = longint'(b) - yh;
    r  = (r > 32767) ? 32767 : ((r < -32768) ? -32768 : r);
    return {yh[15:0], r[15:0]};
  endfunction

  function automatic logic [DW-1:0] put(input logic [DW-1:0] v, input int idx, input logic [15:0] val);
    logic [DW-1:0] t;
    t = v;
    t[DW-1-16*idx -: 16] = val;
    return t;
  endfunction

  function automatic logic [DW-1:0] fill(input logic [15:0] top, input logic [15:0] rest);
    logic [DW-1:0] t;
    t = put('0, 0, top);
    for (int k = 1; k <= MF; k++) t = put(t, k, rest);
    return t;
  endfunction

  // Scoreboard and compare process, on the falling edge.
  always @(negedge CLK) begin
    if (RST) begin
      q.delete();
      seen = 1'b0;
    end else begin
      if (y_valid) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: y_out=%h res_out=%h with nothing outstanding", y_out, res_out);
        end else begin
          check("y_out", y_out, q[0].y);
          check("res_out", res_out, q[0].r);
          check("x_ready_in_out", x_ready, 0);
          if (!seen) begin
            check("latency", cyc, q[0].cyc);
            seen = 1'b1;
          end
          if (y_ready) begin
            last_y   = y_out;
            last_res = res_out;
            $display("[TB] result cycle=%0d y_out=%h res_out=%h", cyc, y_out, res_out);
            void'(q.pop_front());
            pops++;
            seen = 1'b0;
          end
        end
      end
      if (x_valid && x_ready) begin
        mres  = model(model_w, x_in, int'(feat));
        e.y   = mres[31:16];
        e.r   = mres[15:0];
        e.cyc = cyc + (int'(feat) + 2) / 3 + 1;
        q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_w(input logic [DW-1:0] w);
    w_in    = w;
    model_w = w;
    w_load  = 1'b1;
    tick();
    w_load  = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] x, input int f, output int acc_cyc);
    int n;
    x_in    = x;
    feat    = 4'(f);
    x_valid = 1'b1;
    acc_cyc = -1;
    for (n = 0; n < 100; n++) begin
      @(negedge CLK);
      if (x_ready) break;
    end
    if (n == 100) err("accept_timeout");
    else acc_cyc = cyc;
    @(posedge CLK);
    #1;
    x_valid = 1'b0;
  endtask

  task automatic wait_pop(input int p0);
    int n;
    n = 0;
    while (pops == p0 && n < 200) begin
      tick();
      n++;
    end
    if (pops == p0) err("result_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    int t, t2, p0, r;
    logic [DW-1:0] wb, xb, wv, xv, xf;

    wb = put(put('0, 0, 16'h0100), 1, 16'h0200);
    xb = put(put('0, 0, 16'h0700), 1, 16'h0300);

    // Reset with w_load held high: the rise appears right after reset.
    w_in    = wb;
    model_w = wb;
    w_load  = 1'b1;
    RST     = 1'b1;
    repeat (3) tick();
    check("rst_y_valid", y_valid, 0);
    check("rst_x_ready", x_ready, 0);
    check("rst_w_loaded", w_loaded, 0);
    check("rst_y_out", y_out, 0);
    check("rst_res_out", res_out, 0);
    RST = 1'b0;
    tick();
    check("w_loaded_after_rise", w_loaded, 1);
    check("x_ready_idle", x_ready, 1);
    w_load = 1'b0;

    // Basic case.
    p0 = pops;
    send(xb, 1, t);
    wait_pop(p0);
    check("basic_y", last_y, 16'h0700);
    check("basic_res", last_res, 16'h0000);

    // Full width: x_ready low T+1..T+6.
    load_w(fill(16'h0100, 16'h0100));
    xf = fill(16'h0000, 16'h0100);
    p0 = pops;
    send(xf, 15, t);
    for (int i = 1; i <= 6; i++) begin
      check("x_ready_busy", x_ready, 0);
      tick();
    end
    check("x_ready_after_full", x_ready, 1);
    wait_pop(p0);
    check("full_y", last_y, 16'h1000);
    check("full_res", last_res, 16'hF000);

    // Masking: x3 is beyond feat=2; then feat=3 includes it.
    wv = put(put(put(put('0, 0, 16'h0100), 1, 16'h0100), 2, 16'h0100), 3, 16'h0100);
    load_w(wv);
    xv = put(put(put(put('0, 0, 16'h0400), 1, 16'h0100), 2, 16'h0200), 3, 16'h7FFF);
    p0 = pops;
    send(xv, 2, t);
    wait_pop(p0);
    check("mask_y", last_y, 16'h0400);
    check("mask_res", last_res, 16'h0000);
    p0 = pops;
    send(xv, 3, t);
    wait_pop(p0);
    check("feat3_y", last_y, 16'h7FFF);
    check("feat3_res", last_res, 16'h8401);

    // Saturation, positive and negative, plus feat=0.
    load_w(put(put('0, 0, 16'h7F00), 1, 16'h7F00));
    p0 = pops;
    send(put(put('0, 0, 16'h0000), 1, 16'h0100), 1, t);
    wait_pop(p0);
    check("satp_y", last_y, 16'h7FFF);
    check("satp_res", last_res, 16'h8001);
    p0 = pops;
    send(put(put('0, 0, 16'h0100), 1, 16'h0100), 0, t);
    wait_pop(p0);
    check("feat0_y", last_y, 16'h7F00);
    check("feat0_res", last_res, 16'h8200);
    load_w(put(put('0, 0, 16'h8100), 1, 16'h8100));
    p0 = pops;
    send(put(put('0, 0, 16'h7000), 1, 16'h0100), 1, t);
    wait_pop(p0);
    check("satn_y", last_y, 16'h8000);
    check("satn_res", last_res, 16'h7FFF);

    // Mixed-sign vectors, back to back: throughput check.
    wv = '0;
    xv = put('0, 0, 16'h0123);
    for (int k = 0; k <= MF; k++) wv = put(wv, k, 16'(k * 300 - 2000));
    for (int k = 1; k <= MF; k++) xv = put(xv, k, 16'(1000 - k * 173));
    load_w(wv);
    foreach (q[i]) begin end
    for (int f = 2; f <= 15; f += 6) begin
      p0 = pops;
      send(xv, f, t);
      send(fill(16'hFF00, 16'(f * 97)), f, t2);
      check("throughput", t2 - t, (f + 2) / 3 + 2);
      wait_pop(p0 + 1);
    end

    // Backpressure.
    y_ready = 1'b0;
    p0 = pops;
    send(xv, 4, t);
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (y_valid) break;
    end
    check("bp_valid_seen", y_valid, 1);
    tick();
    repeat (10) tick();
    check("bp_held", y_valid, 1);
    check("bp_not_popped", pops, p0);
    y_ready = 1'b1;
    r = cyc;
    send(xb, 1, t);
    check("bp_accept_cycle", t, r + 1);
    wait_pop(p0 + 1);

    // Weight reload during MAC.
    load_w(fill(16'h0100, 16'h0100));
    xf = fill(16'h0000, 16'h0100);
    p0 = pops;
    send(xf, 15, t);
    w_in    = fill(16'h0080, 16'h0080);
    model_w = w_in;
    w_load  = 1'b1;
    tick();
    w_load  = 1'b0;
    wait_pop(p0);
    check("reload_old_w", last_y, 16'h1000);
    check("reload_x_ready_low", x_ready, 0);
    tick();
    check("reload_x_ready_back", x_ready, 1);
    p0 = pops;
    send(xf, 15, t);
    wait_pop(p0);
    check("reload_new_y", last_y, 16'h0800);
    check("reload_new_res", last_res, 16'hF800);

    // Reset mid-MAC.
    send(xf, 15, t);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rstmac_y_valid", y_valid, 0);
    check("rstmac_x_ready", x_ready, 0);
    check("rstmac_w_loaded", w_loaded, 0);
    x_in    = xb;
    feat    = 4'd1;
    x_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rstmac_idle_x_ready", x_ready, 0);
      check("rstmac_idle_y_valid", y_valid, 0);
    end
    x_valid = 1'b0;
    load_w(wb);
    check("rstmac_reloaded", w_loaded, 1);
    p0 = pops;
    send(xb, 1, t);
    wait_pop(p0);
    check("rstmac_recover_y", last_y, 16'h0700);

    repeat (3) tick();
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
